// File: rtl/fuzz_stim_gen.sv
// ---------------------------------------------------------------------------
// fuzz_stim_gen
//
// Stimulus generator for a dual-DUT equivalence harness. A 64-bit Fibonacci
// LFSR supplies pseudo-random vectors that are sliced onto wire0..wire3 and
// fed to both DUT copies. Every issued vector is counted, and its index
// travels down a CHECK_LAT-deep pipe so that the harness mismatch flag can be
// tied back to the vector that caused it. The run stops on the first
// qualified mismatch (latching the failing index) or ends after num_vectors
// vectors plus a CHECK_LAT-cycle drain.
//
// Optional build macro:
//   FUZZ_CORNER_EN - when defined, the first four vectors of every run are
//                    fixed corners (all-zero, all-one, signed min, signed
//                    max) before LFSR data begins. The LFSR holds during
//                    corners.
//
// Parameters:
//   CNT_W      width of num_vectors, vec_count and fail_index
//   CHECK_LAT  cycles between a vector on wireN and its mismatch sample (1..8)
//
// Ports:
//   clk          in   single clock, posedge
//   rst_n        in   asynchronous active-low reset
//   start        in   run request pulse, honoured only in IDLE or DONE
//   seed         in   32-bit LFSR seed, sampled on an accepted start
//   num_vectors  in   vectors to issue; 0 finishes immediately without fail
//   mismatch     in   harness compare result (1 = outputs differ)
//   wire0        out  18-bit unsigned stimulus
//   wire1        out  14-bit signed stimulus
//   wire2        out  10-bit signed stimulus
//   wire3        out  21-bit signed stimulus
//   vec_valid    out  wireN carry a live vector this cycle
//   busy         out  run in progress (RUN or DRAIN)
//   done         out  run finished (level)
//   fail         out  a mismatch was caught in this run
//   fail_index   out  0-based index of the first failing vector
//   vec_count    out  vectors issued in this run (saturating)
// ---------------------------------------------------------------------------
module fuzz_stim_gen #(
  parameter int CNT_W     = 32,
  parameter int CHECK_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             mismatch,
  output logic [17:0]      wire0,
  output logic [13:0]      wire1,
  output logic [9:0]       wire2,
  output logic [20:0]      wire3,
  output logic             vec_valid,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] fail_index,
  output logic [CNT_W-1:0] vec_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [3:0]       LAT_M1 = 4'(CHECK_LAT - 1);

`ifdef FUZZ_CORNER_EN
  localparam logic [CNT_W-1:0] CORNER_N = CNT_W'(4);
`endif

  // One Fibonacci step: taps 64,63,61,60 (bits 63,62,60,59), shift left,
  // feedback enters at bit 0.
  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    logic fb;
    fb = s[63] ^ s[62] ^ s[60] ^ s[59];
    return {s[62:0], fb};
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + ONE;
    end
  endfunction

  state_t                        state_q, state_d;
  logic [63:0]                   lfsr_q, lfsr_d;
  logic [17:0]                   wire0_q, wire0_d;
  logic [13:0]                   wire1_q, wire1_d;
  logic [9:0]                    wire2_q, wire2_d;
  logic [20:0]                   wire3_q, wire3_d;
  logic                          vec_valid_q, vec_valid_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          fail_q, fail_d;
  logic [CNT_W-1:0]              fail_index_q, fail_index_d;
  logic [CNT_W-1:0]              vec_count_q, vec_count_d;
  logic [CNT_W-1:0]              num_q, num_d;
  logic [3:0]                    drain_q, drain_d;
  logic [CHECK_LAT-1:0]          vpipe_q, vpipe_d;
  logic [CHECK_LAT-1:0][CNT_W-1:0] ipipe_q, ipipe_d;

  logic                          issue_s;
  logic [CNT_W-1:0]              issue_idx_s;
  logic [63:0]                   lfsr_src_s;
  logic [63:0]                   lfsr_next_s;
  logic                          chk_hit_s;

  assign wire0      = wire0_q;
  assign wire1      = wire1_q;
  assign wire2      = wire2_q;
  assign wire3      = wire3_q;
  assign vec_valid  = vec_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign fail_index = fail_index_q;
  assign vec_count  = vec_count_q;

  // Next-state, vector issue, check pipe and fail capture.
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    wire0_d      = wire0_q;
    wire1_d      = wire1_q;
    wire2_d      = wire2_q;
    wire3_d      = wire3_q;
    vec_valid_d  = 1'b0;
    vec_count_d  = vec_count_q;
    num_d        = num_q;
    drain_d      = drain_q;
    fail_d       = fail_q;
    fail_index_d = fail_index_q;
    issue_s      = 1'b0;
    issue_idx_s  = vec_count_q;
    lfsr_src_s   = lfsr_q;
    lfsr_next_s  = 64'd0;

    // The index of the vector currently on wireN is vec_count-1; it rides
    // alongside vec_valid so the delayed slot names the vector being judged.
    vpipe_d[0] = vec_valid_q;
    ipipe_d[0] = vec_count_q - ONE;
    for (int i = 1; i < CHECK_LAT; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
      ipipe_d[i] = ipipe_q[i-1];
    end

    // Only a mismatch that lines up with a live delayed vector counts, and
    // only the first one in a run.
    chk_hit_s = vpipe_q[CHECK_LAT-1] && mismatch && !fail_q &&
                ((state_q == S_RUN) || (state_q == S_DRAIN));

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          lfsr_src_s   = {~seed, seed};
          lfsr_d       = lfsr_src_s;
          vec_count_d  = {CNT_W{1'b0}};
          fail_d       = 1'b0;
          fail_index_d = {CNT_W{1'b0}};
          num_d        = num_vectors;
          drain_d      = 4'd0;
          // Stale entries from an aborted run must not alias into this one.
          vpipe_d      = {CHECK_LAT{1'b0}};
          ipipe_d      = '0;
          if (num_vectors == {CNT_W{1'b0}}) begin
            state_d = S_DONE;
          end else begin
            // Vector 0 goes out on the same edge that accepts start.
            state_d     = S_RUN;
            issue_s     = 1'b1;
            issue_idx_s = {CNT_W{1'b0}};
          end
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (chk_hit_s) begin
          fail_d       = 1'b1;
          fail_index_d = ipipe_q[CHECK_LAT-1];
          state_d      = S_DONE;
        end else if (vec_count_q == num_q) begin
          state_d = S_DRAIN;
          drain_d = 4'd0;
        end else begin
          issue_s = 1'b1;
        end
      end
      S_DRAIN: begin
        if (chk_hit_s) begin
          fail_d       = 1'b1;
          fail_index_d = ipipe_q[CHECK_LAT-1];
          state_d      = S_DONE;
        end else if (drain_q == LAT_M1) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (issue_s) begin
      vec_valid_d = 1'b1;
      vec_count_d = sat_inc(issue_idx_s);
`ifdef FUZZ_CORNER_EN
      if (issue_idx_s < CORNER_N) begin
        // Corners hold the LFSR so LFSR vector 0 follows the last corner.
        lfsr_d = lfsr_src_s;
        case (issue_idx_s[1:0])
          2'd0: begin
            wire0_d = 18'h00000;
            wire1_d = 14'h0000;
            wire2_d = 10'h000;
            wire3_d = 21'h000000;
          end
          2'd1: begin
            wire0_d = 18'h3FFFF;
            wire1_d = 14'h3FFF;
            wire2_d = 10'h3FF;
            wire3_d = 21'h1FFFFF;
          end
          2'd2: begin
            wire0_d = 18'h20000;
            wire1_d = 14'h2000;
            wire2_d = 10'h200;
            wire3_d = 21'h100000;
          end
          2'd3: begin
            wire0_d = 18'h1FFFF;
            wire1_d = 14'h1FFF;
            wire2_d = 10'h1FF;
            wire3_d = 21'h0FFFFF;
          end
          default: begin
            wire0_d = 18'h00000;
            wire1_d = 14'h0000;
            wire2_d = 10'h000;
            wire3_d = 21'h000000;
          end
        endcase
      end else begin
        lfsr_next_s = lfsr_step(lfsr_src_s);
        lfsr_d      = lfsr_next_s;
        wire0_d     = lfsr_next_s[17:0];
        wire1_d     = lfsr_next_s[31:18];
        wire2_d     = lfsr_next_s[41:32];
        wire3_d     = lfsr_next_s[62:42];
      end
`else
      lfsr_next_s = lfsr_step(lfsr_src_s);
      lfsr_d      = lfsr_next_s;
      wire0_d     = lfsr_next_s[17:0];
      wire1_d     = lfsr_next_s[31:18];
      wire2_d     = lfsr_next_s[41:32];
      wire3_d     = lfsr_next_s[62:42];
`endif
    end else begin
      vec_valid_d = 1'b0;
    end

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lfsr_q       <= 64'd0;
      wire0_q      <= 18'd0;
      wire1_q      <= 14'd0;
      wire2_q      <= 10'd0;
      wire3_q      <= 21'd0;
      vec_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_index_q <= {CNT_W{1'b0}};
      vec_count_q  <= {CNT_W{1'b0}};
      num_q        <= {CNT_W{1'b0}};
      drain_q      <= 4'd0;
      vpipe_q      <= {CHECK_LAT{1'b0}};
      ipipe_q      <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      wire0_q      <= wire0_d;
      wire1_q      <= wire1_d;
      wire2_q      <= wire2_d;
      wire3_q      <= wire3_d;
      vec_valid_q  <= vec_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      fail_index_q <= fail_index_d;
      vec_count_q  <= vec_count_d;
      num_q        <= num_d;
      drain_q      <= drain_d;
      vpipe_q      <= vpipe_d;
      ipipe_q      <= ipipe_d;
    end
  end

endmodule

// File: tb/tb_fuzz_stim_gen.sv
// ---------------------------------------------------------------------------
// tb_fuzz_stim_gen
//
// Directed bench for fuzz_stim_gen. Inputs change and outputs are sampled on
// the falling clock edge. Expected vectors come from an independent model of
// the 64-bit LFSR (and of the corner vectors when FUZZ_CORNER_EN is defined).
// ---------------------------------------------------------------------------
module tb_fuzz_stim_gen;

  localparam int CNT_W = 32;
  localparam int LAT   = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [31:0]      seed;
  logic [CNT_W-1:0] num_vectors;
  logic             mismatch;
  logic [17:0]      wire0;
  logic [13:0]      wire1;
  logic [9:0]       wire2;
  logic [20:0]      wire3;
  logic             vec_valid;
  logic             busy;
  logic             done;
  logic             fail;
  logic [CNT_W-1:0] fail_index;
  logic [CNT_W-1:0] vec_count;
  logic [62:0]      vec_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign vec_s = {wire3, wire2, wire1, wire0};

  fuzz_stim_gen #(.CNT_W(CNT_W), .CHECK_LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seed       (seed),
    .num_vectors(num_vectors),
    .mismatch   (mismatch),
    .wire0      (wire0),
    .wire1      (wire1),
    .wire2      (wire2),
    .wire3      (wire3),
    .vec_valid  (vec_valid),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .fail_index (fail_index),
    .vec_count  (vec_count)
  );

  function automatic logic [63:0] m_step(input logic [63:0] s);
    logic fb;
    fb = s[63] ^ s[62] ^ s[60] ^ s[59];
    return {s[62:0], fb};
  endfunction

  // Expected {wire3,wire2,wire1,wire0} for vector k of a run seeded with sd.
  function automatic logic [62:0] exp_vec(input logic [31:0] sd, input int k);
    logic [63:0] m;
    int          n;
    m = {~sd, sd};
`ifdef FUZZ_CORNER_EN
    if (k == 0) return 63'd0;
    if (k == 1) return {63{1'b1}};
    if (k == 2) return {21'h100000, 10'h200, 14'h2000, 18'h20000};
    if (k == 3) return {21'h0FFFFF, 10'h1FF, 14'h1FFF, 18'h1FFFF};
    n = k - 3;
`else
    n = k + 1;
`endif
    for (int i = 0; i < n; i++) m = m_step(m);
    return m[62:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_start(input logic [31:0] sd, input logic [CNT_W-1:0] n);
    @(negedge clk);
    seed        = sd;
    num_vectors = n;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b1;
    seed        = $urandom;
    num_vectors = CNT_W'($urandom_range(1, 50));
    mismatch    = 1'b1;

    // 1: reset with live inputs, then release while idle
    repeat (3) @(negedge clk);
    chk("rst_wires", {1'b0, vec_s}, 64'd0);
    chk("rst_flags", {60'd0, vec_valid, busy, done, fail}, 64'd0);
    chk("rst_fail_index", {32'd0, fail_index}, 64'd0);
    chk("rst_vec_count", {32'd0, vec_count}, 64'd0);
    start    = 1'b0;
    mismatch = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_flags", {60'd0, vec_valid, busy, done, fail}, 64'd0);

    // 2: seed 1, ten clean vectors
    run_start(32'h1, 10);
`ifndef FUZZ_CORNER_EN
    chk("t2_v0_hand", {1'b0, vec_s}, {1'b0, 21'h1FFFFF, 10'h3FC, 14'h0000, 18'h00002});
`endif
    for (int k = 0; k < 10; k++) begin
      chk("t2_vec", {1'b0, vec_s}, {1'b0, exp_vec(32'h1, k)});
      chk("t2_valid_busy", {62'd0, vec_valid, busy}, 64'd3);
      chk("t2_count", {32'd0, vec_count}, 64'(k + 1));
      @(negedge clk);
    end
    for (int d = 0; d < LAT; d++) begin
      chk("t2_drain_flags", {61'd0, vec_valid, busy, done}, 64'd2);
      chk("t2_drain_hold", {1'b0, vec_s}, {1'b0, exp_vec(32'h1, 9)});
      @(negedge clk);
    end
    chk("t2_done_flags", {60'd0, vec_valid, busy, done, fail}, 64'd2);
    chk("t2_count_final", {32'd0, vec_count}, 64'd10);

    // 3: mismatch reported for vector 37
    run_start(32'hDEAD_BEEF, 100);
    for (int k = 0; k <= 37 + LAT; k++) begin
      if (k % 8 == 0 || k >= 36) begin
        chk("t3_vec", {1'b0, vec_s}, {1'b0, exp_vec(32'hDEAD_BEEF, k)});
        chk("t3_valid", {63'd0, vec_valid}, 64'd1);
      end
      if (k == 37 + LAT) mismatch = 1'b1;
      @(negedge clk);
    end
    mismatch = 1'b0;
    chk("t3_fail_flags", {60'd0, vec_valid, busy, done, fail}, 64'd3);
    chk("t3_fail_index", {32'd0, fail_index}, 64'd37);
    chk("t3_count", {32'd0, vec_count}, 64'(38 + LAT));
    mismatch = 1'b1;
    repeat (3) @(negedge clk);
    mismatch = 1'b0;
    chk("t3_index_kept", {32'd0, fail_index}, 64'd37);
    chk("t3_after_flags", {60'd0, vec_valid, busy, done, fail}, 64'd3);
    chk("t3_count_kept", {32'd0, vec_count}, 64'(38 + LAT));

    // 4: zero vectors
    run_start(32'h0BAD_F00D, 0);
    chk("t4_flags", {60'd0, vec_valid, busy, done, fail}, 64'd2);
    chk("t4_count", {32'd0, vec_count}, 64'd0);
    chk("t4_fail_index", {32'd0, fail_index}, 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t4_no_valid", {62'd0, vec_valid, done}, 64'd1);
    end

    // 5: ignored mismatch and ignored restart, then reset mid-run
    mismatch = 1'b1;
    @(negedge clk);
    mismatch = 1'b0;
    chk("t5_done_mm_ignored", {63'd0, fail}, 64'd0);
    run_start(32'h1234_5678, 5);
    mismatch = 1'b1;
    chk("t5_v0", {1'b0, vec_s}, {1'b0, exp_vec(32'h1234_5678, 0)});
    @(negedge clk);
    mismatch = 1'b0;
    start    = 1'b1;
    chk("t5_v1", {1'b0, vec_s}, {1'b0, exp_vec(32'h1234_5678, 1)});
    @(negedge clk);
    start = 1'b0;
    chk("t5_v2_no_restart", {1'b0, vec_s}, {1'b0, exp_vec(32'h1234_5678, 2)});
    chk("t5_count_v2", {32'd0, vec_count}, 64'd3);
    @(negedge clk);
    chk("t5_v3", {1'b0, vec_s}, {1'b0, exp_vec(32'h1234_5678, 3)});
    @(negedge clk);
    chk("t5_v4", {1'b0, vec_s}, {1'b0, exp_vec(32'h1234_5678, 4)});
    repeat (LAT + 1) @(negedge clk);
    chk("t5_end_flags", {60'd0, vec_valid, busy, done, fail}, 64'd2);
    chk("t5_end_count", {32'd0, vec_count}, 64'd5);

    run_start(32'h5555_AAAA, 20);
    repeat (3) @(negedge clk);
    chk("t5_mid_run", {31'd0, vec_valid, vec_count}, {31'd0, 1'b1, 32'd4});
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_wires", {1'b0, vec_s}, 64'd0);
    chk("t5_rst_flags", {60'd0, vec_valid, busy, done, fail}, 64'd0);
    chk("t5_rst_count", {32'd0, vec_count}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_idle_after_rst", {60'd0, vec_valid, busy, done, fail}, 64'd0);

    // 6: six vectors (corner vectors first when enabled)
    run_start(32'hCAFE_F00D, 6);
    for (int k = 0; k < 6; k++) begin
      chk("t6_vec", {1'b0, vec_s}, {1'b0, exp_vec(32'hCAFE_F00D, k)});
      @(negedge clk);
    end
    repeat (LAT) @(negedge clk);
    chk("t6_done", {60'd0, vec_valid, busy, done, fail}, 64'd2);
    chk("t6_count", {32'd0, vec_count}, 64'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
